// File: rtl/common_ram_port_arb.sv
// Round-robin arbiter sharing one single-port RAM macro among N_REQ requesters,
// with read-data return routing and an idle-driven enable for the RAM clock gate.
module common_ram_port_arb #(
  parameter int N_REQ     = 2,
  parameter int AW        = 10,
  parameter int DW        = 32,
  parameter int RAM_LAT   = 1,
  parameter int IDLE_HOLD = 4
) (
  input  logic                clk_i,
  input  logic                rst_n_i,
  input  logic [N_REQ-1:0]    req_i,
  input  logic [N_REQ-1:0]    we_i,
  input  logic [N_REQ*AW-1:0] addr_i,
  input  logic [N_REQ*DW-1:0] wdata_i,
  output logic [N_REQ-1:0]    gnt_o,
  output logic [N_REQ-1:0]    rvalid_o,
  output logic [DW-1:0]       rdata_o,
  output logic                ram_clk_en_o,
  output logic                ram_cs_o,
  output logic                ram_we_o,
  output logic [AW-1:0]       ram_addr_o,
  output logic [DW-1:0]       ram_wdata_o,
  input  logic [DW-1:0]       ram_rdata_i
);

  localparam int            IW   = (N_REQ > 1) ? $clog2(N_REQ) : 1;
  localparam logic [IW-1:0] LAST = IW'(N_REQ - 1);
  localparam logic [7:0]    HOLD = 8'(IDLE_HOLD);

  typedef enum logic [1:0] {
    ST_OFF  = 2'd0,
    ST_WAKE = 2'd1,
    ST_ON   = 2'd2
  } state_e;

  state_e             state_q;
  logic [IW-1:0]      ptr_q;
  logic [7:0]         idle_q;
  logic               clk_en_q;
  logic [RAM_LAT-1:0] pipe_vld_q;
  logic [IW-1:0]      pipe_id_q [RAM_LAT];

  logic [N_REQ-1:0] req_hi;
  logic [N_REQ-1:0] gnt_vec;
  logic [IW-1:0]    gnt_idx;
  logic             gnt_any;
  logic             gnt_we;
  logic             rd_push;
  logic             rd_busy;
  logic [7:0]       idle_inc;

  // Requests at or above the pointer take priority; otherwise wrap to the lowest.
  always_comb begin
    req_hi  = '0;
    gnt_idx = '0;
    gnt_any = 1'b0;
    for (int i = 0; i < N_REQ; i++) begin
      req_hi[i] = req_i[i] && (i[IW-1:0] >= ptr_q);
    end
    if (state_q == ST_ON) begin
      gnt_any = |req_i;
      if (|req_hi) begin
        for (int i = N_REQ - 1; i >= 0; i--) begin
          if (req_hi[i]) gnt_idx = i[IW-1:0];
        end
      end else begin
        for (int i = N_REQ - 1; i >= 0; i--) begin
          if (req_i[i]) gnt_idx = i[IW-1:0];
        end
      end
    end
  end

  always_comb begin
    gnt_vec     = '0;
    gnt_we      = 1'b0;
    ram_addr_o  = '0;
    ram_wdata_o = '0;
    for (int k = 0; k < N_REQ; k++) begin
      if (gnt_any && (gnt_idx == k[IW-1:0])) begin
        gnt_vec[k]  = 1'b1;
        gnt_we      = we_i[k];
        ram_addr_o  = addr_i[k*AW +: AW];
        ram_wdata_o = wdata_i[k*DW +: DW];
      end
    end
  end

  assign gnt_o    = gnt_vec;
  assign ram_cs_o = gnt_any;
  assign ram_we_o = gnt_any & gnt_we;
  assign rd_push  = gnt_any & ~gnt_we;
  assign rd_busy  = |pipe_vld_q;
  assign idle_inc = idle_q + 8'd1;

  always_comb begin
    rvalid_o = '0;
    for (int k = 0; k < N_REQ; k++) begin
      rvalid_o[k] = pipe_vld_q[RAM_LAT-1] && (pipe_id_q[RAM_LAT-1] == k[IW-1:0]);
    end
  end

  assign rdata_o      = pipe_vld_q[RAM_LAT-1] ? ram_rdata_i : '0;
  assign ram_clk_en_o = clk_en_q;

  // The read pipeline counts as activity, so the clock is never gated under a read.
  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      state_q    <= ST_OFF;
      ptr_q      <= '0;
      idle_q     <= '0;
      clk_en_q   <= 1'b0;
      pipe_vld_q <= '0;
      for (int s = 0; s < RAM_LAT; s++) pipe_id_q[s] <= '0;
    end else begin
      if (gnt_any) ptr_q <= (gnt_idx == LAST) ? '0 : gnt_idx + 1'b1;
      for (int s = RAM_LAT - 1; s > 0; s--) begin
        pipe_vld_q[s] <= pipe_vld_q[s-1];
        pipe_id_q[s]  <= pipe_id_q[s-1];
      end
      pipe_vld_q[0] <= rd_push;
      pipe_id_q[0]  <= gnt_idx;
      case (state_q)
        ST_OFF: begin
          idle_q <= '0;
          if (|req_i) begin
            state_q  <= ST_WAKE;
            clk_en_q <= 1'b1;
          end
        end
        ST_WAKE: begin
          idle_q   <= '0;
          state_q  <= ST_ON;
          clk_en_q <= 1'b1;
        end
        ST_ON: begin
          if ((|req_i) || rd_busy) begin
            idle_q <= '0;
          end else if (idle_inc >= HOLD) begin
            idle_q   <= HOLD;
            state_q  <= ST_OFF;
            clk_en_q <= 1'b0;
          end else begin
            idle_q <= idle_inc;
          end
        end
        default: begin
          state_q  <= ST_OFF;
          clk_en_q <= 1'b0;
          idle_q   <= '0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_common_ram_port_arb.sv
// Directed bench: two arbiter instances (read latency 1 and 3), each backed by
// a small behavioural RAM macro clocked only while its clock enable is high.
module tb_common_ram_port_arb;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  int n_checks = 0;
  int n_pass   = 0;

  // ---------------- instance A: RAM_LAT = 1 ----------------
  logic        rst_a_n;
  logic [1:0]  req_a, we_a, gnt_a, rvalid_a;
  logic [19:0] addr_a;
  logic [63:0] wdata_a;
  logic [31:0] rdata_a, ram_wdata_a, ram_rdata_a;
  logic        en_a, cs_a, rwe_a;
  logic [9:0]  ram_addr_a;
  logic [31:0] mem_a [1024];

  common_ram_port_arb #(.N_REQ(2), .AW(10), .DW(32), .RAM_LAT(1), .IDLE_HOLD(4)) dut_a (
    .clk_i(clk), .rst_n_i(rst_a_n), .req_i(req_a), .we_i(we_a), .addr_i(addr_a),
    .wdata_i(wdata_a), .gnt_o(gnt_a), .rvalid_o(rvalid_a), .rdata_o(rdata_a),
    .ram_clk_en_o(en_a), .ram_cs_o(cs_a), .ram_we_o(rwe_a), .ram_addr_o(ram_addr_a),
    .ram_wdata_o(ram_wdata_a), .ram_rdata_i(ram_rdata_a)
  );

  always @(posedge clk) begin
    if (en_a && cs_a) begin
      if (rwe_a) mem_a[ram_addr_a] <= ram_wdata_a;
      else       ram_rdata_a <= mem_a[ram_addr_a];
    end
  end

  // ---------------- instance B: RAM_LAT = 3 ----------------
  logic        rst_b_n;
  logic [1:0]  req_b, we_b, gnt_b, rvalid_b;
  logic [19:0] addr_b;
  logic [63:0] wdata_b;
  logic [31:0] rdata_b, ram_wdata_b, ram_rdata_b;
  logic        en_b, cs_b, rwe_b;
  logic [9:0]  ram_addr_b;
  logic [31:0] mem_b [1024];
  logic [31:0] rb0, rb1;

  common_ram_port_arb #(.N_REQ(2), .AW(10), .DW(32), .RAM_LAT(3), .IDLE_HOLD(4)) dut_b (
    .clk_i(clk), .rst_n_i(rst_b_n), .req_i(req_b), .we_i(we_b), .addr_i(addr_b),
    .wdata_i(wdata_b), .gnt_o(gnt_b), .rvalid_o(rvalid_b), .rdata_o(rdata_b),
    .ram_clk_en_o(en_b), .ram_cs_o(cs_b), .ram_we_o(rwe_b), .ram_addr_o(ram_addr_b),
    .ram_wdata_o(ram_wdata_b), .ram_rdata_i(ram_rdata_b)
  );

  always @(posedge clk) begin
    if (en_b) begin
      rb1         <= rb0;
      ram_rdata_b <= rb1;
      if (cs_b && rwe_b)  mem_b[ram_addr_b] <= ram_wdata_b;
      if (cs_b && !rwe_b) rb0 <= mem_b[ram_addr_b];
    end
  end

  // ---------------- helpers ----------------
  task automatic check(input string tag, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, act, exp);
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic mid();
    @(negedge clk);
  endtask

  task automatic set_a(input logic [1:0] r, input logic [1:0] w,
                       input logic [9:0] a0, input logic [31:0] d0,
                       input logic [9:0] a1, input logic [31:0] d1);
    req_a = r; we_a = w; addr_a = {a1, a0}; wdata_a = {d1, d0};
  endtask

  task automatic set_b(input logic [1:0] r, input logic [1:0] w,
                       input logic [9:0] a0, input logic [31:0] d0,
                       input logic [9:0] a1, input logic [31:0] d1);
    req_b = r; we_b = w; addr_b = {a1, a0}; wdata_b = {d1, d0};
  endtask

  logic [1:0] rr_exp [4];

  initial begin
    rst_a_n = 1'b0;
    rst_b_n = 1'b0;
    set_a(2'b00, 2'b00, 10'h0, 32'h0, 10'h0, 32'h0);
    set_b(2'b00, 2'b00, 10'h0, 32'h0, 10'h0, 32'h0);
    rr_exp[0] = 2'b01; rr_exp[1] = 2'b10; rr_exp[2] = 2'b01; rr_exp[3] = 2'b10;

    // reset state
    mid();
    check("rst_gnt",    64'(gnt_a),       64'(2'b00));
    check("rst_rvalid", 64'(rvalid_a),    64'(2'b00));
    check("rst_rdata",  64'(rdata_a),     64'(0));
    check("rst_clk_en", 64'(en_a),        64'(0));
    check("rst_cs",     64'(cs_a),        64'(0));
    check("rst_we",     64'(rwe_a),       64'(0));
    check("rst_addr",   64'(ram_addr_a),  64'(0));
    check("rst_wdata",  64'(ram_wdata_a), 64'(0));

    step(); rst_a_n = 1'b1;

    // ---- A: wake and write ----
    step(); set_a(2'b01, 2'b01, 10'h005, 32'hA5A5_A5A5, 10'h0, 32'h0);
    mid();
    check("a_c0_clk_en", 64'(en_a),  64'(0));
    check("a_c0_gnt",    64'(gnt_a), 64'(2'b00));
    step(); mid();
    check("a_c1_clk_en", 64'(en_a),  64'(1));
    check("a_c1_gnt",    64'(gnt_a), 64'(2'b00));
    step(); mid();
    check("a_c2_gnt",   64'(gnt_a),       64'(2'b01));
    check("a_c2_cs",    64'(cs_a),        64'(1));
    check("a_c2_we",    64'(rwe_a),       64'(1));
    check("a_c2_addr",  64'(ram_addr_a),  64'(10'h005));
    check("a_c2_wdata", 64'(ram_wdata_a), 64'(32'hA5A5_A5A5));

    // ---- A: read back ----
    step(); set_a(2'b01, 2'b00, 10'h005, 32'h0, 10'h0, 32'h0);
    mid();
    check("a_rd_gnt", 64'(gnt_a),    64'(2'b01));
    check("a_rd_we",  64'(rwe_a),    64'(0));
    check("a_rd_rv0", 64'(rvalid_a), 64'(2'b00));
    step(); set_a(2'b10, 2'b10, 10'h0, 32'h0, 10'h007, 32'h0BAD_F00D);
    mid();
    check("a_rd_rvalid", 64'(rvalid_a), 64'(2'b01));
    check("a_rd_rdata",  64'(rdata_a),  64'(32'hA5A5_A5A5));
    check("a_w1_gnt",    64'(gnt_a),    64'(2'b10));

    // ---- A: round robin with both requesting ----
    for (int i = 0; i < 4; i++) begin
      step(); set_a(2'b11, 2'b11, 10'(8 + i), 32'(i), 10'(16 + i), 32'(i + 100));
      mid();
      check($sformatf("a_rr_gnt%0d", i), 64'(gnt_a), 64'(rr_exp[i]));
      check($sformatf("a_rr_rv%0d", i),  64'(rvalid_a), 64'(2'b00));
    end

    // ---- A: idle gating ----
    step(); set_a(2'b00, 2'b00, 10'h0, 32'h0, 10'h0, 32'h0);
    mid();
    check("a_ptr_end", 64'(dut_a.ptr_q), 64'(0));
    check("a_idle_clk_en0", 64'(en_a), 64'(1));
    for (int i = 1; i < 4; i++) begin
      step(); mid();
      check($sformatf("a_idle_clk_en%0d", i), 64'(en_a), 64'(1));
    end
    step(); mid();
    check("a_off_clk_en", 64'(en_a),          64'(0));
    check("a_off_state",  64'(dut_a.state_q), 64'(0));

    // ---- B: RAM_LAT=3, write then read ----
    step(); rst_b_n = 1'b1;
    step(); set_b(2'b01, 2'b01, 10'h009, 32'h1234_5678, 10'h0, 32'h0);
    mid();
    check("b_c0_clk_en", 64'(en_b), 64'(0));
    step(); mid();
    check("b_c1_clk_en", 64'(en_b), 64'(1));
    step(); mid();
    check("b_c2_gnt", 64'(gnt_b), 64'(2'b01));
    step(); set_b(2'b01, 2'b00, 10'h009, 32'h0, 10'h0, 32'h0);
    mid();
    check("b_rd_gnt", 64'(gnt_b), 64'(2'b01));
    step(); set_b(2'b00, 2'b00, 10'h0, 32'h0, 10'h0, 32'h0);
    mid();
    check("b_c4_rvalid", 64'(rvalid_b), 64'(2'b00));
    step(); mid();
    check("b_c5_rvalid", 64'(rvalid_b), 64'(2'b00));
    step(); mid();
    check("b_c6_rvalid", 64'(rvalid_b), 64'(2'b01));
    check("b_c6_rdata",  64'(rdata_b),  64'(32'h1234_5678));
    step(); mid();
    check("b_c7_rvalid", 64'(rvalid_b), 64'(2'b00));
    check("b_c7_rdata",  64'(rdata_b),  64'(0));
    step(); mid();
    check("b_c8_clk_en", 64'(en_b), 64'(1));
    step(); mid();
    check("b_c9_clk_en", 64'(en_b), 64'(1));

    // ---- B: request on the cycle the idle count would expire ----
    step(); set_b(2'b10, 2'b10, 10'h0, 32'h0, 10'h003, 32'hCAFE_0003);
    mid();
    check("b_c10_gnt",    64'(gnt_b), 64'(2'b10));
    check("b_c10_clk_en", 64'(en_b),  64'(1));
    step(); set_b(2'b00, 2'b00, 10'h0, 32'h0, 10'h0, 32'h0);
    mid();
    check("b_c11_clk_en", 64'(en_b), 64'(1));
    step(); step(); step(); mid();
    check("b_c14_clk_en", 64'(en_b), 64'(1));
    step(); mid();
    check("b_c15_clk_en", 64'(en_b), 64'(0));

    // ---- B: reset pulse just after a read grant ----
    step(); set_b(2'b01, 2'b00, 10'h009, 32'h0, 10'h0, 32'h0);
    step(); step(); mid();
    check("b_c18_gnt", 64'(gnt_b), 64'(2'b01));
    step(); set_b(2'b00, 2'b00, 10'h0, 32'h0, 10'h0, 32'h0);
    rst_b_n = 1'b0;
    #1;
    check("b_rst_clk_en", 64'(en_b),     64'(0));
    check("b_rst_gnt",    64'(gnt_b),    64'(2'b00));
    check("b_rst_rvalid", 64'(rvalid_b), 64'(2'b00));
    check("b_rst_cs",     64'(cs_b),     64'(0));
    step(); rst_b_n = 1'b1;
    mid();
    check("b_c20_rvalid", 64'(rvalid_b), 64'(2'b00));
    for (int i = 21; i < 24; i++) begin
      step(); mid();
      check($sformatf("b_c%0d_rvalid", i), 64'(rvalid_b), 64'(2'b00));
      check($sformatf("b_c%0d_rdata", i),  64'(rdata_b),  64'(0));
    end

    // ---- B: wake again after reset ----
    step(); set_b(2'b01, 2'b00, 10'h009, 32'h0, 10'h0, 32'h0);
    mid();
    check("b_c24_clk_en", 64'(en_b),  64'(0));
    check("b_c24_gnt",    64'(gnt_b), 64'(2'b00));
    step(); mid();
    check("b_c25_clk_en", 64'(en_b),  64'(1));
    check("b_c25_gnt",    64'(gnt_b), 64'(2'b00));
    step(); mid();
    check("b_c26_gnt", 64'(gnt_b), 64'(2'b01));
    step(); set_b(2'b00, 2'b00, 10'h0, 32'h0, 10'h0, 32'h0);
    step(); step(); mid();
    check("b_c29_rvalid", 64'(rvalid_b), 64'(2'b01));
    check("b_c29_rdata",  64'(rdata_b),  64'(32'h1234_5678));

    step(); step();
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/common_ram_port_arb.md
Name: common_ram_port_arb

Overview:
- Round-robin arbiter and sequencer that shares one single-port RAM macro among N_REQ requesters in the fpga_ram simulation/implementation tree.
- Generates the macro strobes (cs, we, addr, wdata) and routes read data back to the owning requester.
- Drives ram_clk_en, the enable input of the common AND2 clock-gate cell in front of the macro. After IDLE_HOLD idle cycles it gates the RAM clock off, and wakes it up again on demand.

Parameters:
N_REQ, 2, number of requesters (2..8)
AW, 10, address width
DW, 32, data width
RAM_LAT, 1, macro read latency in clk_i cycles after cs (1..3)
IDLE_HOLD, 4, idle cycles in ON before clock is gated off (1..255)

Ports:
clk_i  in  1  clock
rst_n_i  in  1  asynchronous active-low reset
req_i  in  N_REQ  per-requester access request, held until gnt
we_i  in  N_REQ  per-requester write enable (1=write), valid with req
addr_i  in  N_REQ*AW  packed addresses, requester k at [k*AW +: AW]
wdata_i  in  N_REQ*DW  packed write data
gnt_o  out  N_REQ  one-hot grant, access accepted this cycle
rvalid_o  out  N_REQ  one-hot read-data valid
rdata_o  out  DW  read data, shared bus, qualified by rvalid_o
ram_clk_en_o  out  1  registered enable to AND2 clock-gate cell
ram_cs_o  out  1  macro chip select
ram_we_o  out  1  macro write enable
ram_addr_o  out  AW  macro address
ram_wdata_o  out  DW  macro write data
ram_rdata_i  in  DW  macro read data

Behaviour:
- Reset (async assert, sync release): state=OFF, rr pointer=0, idle counter=0, read pipeline empty. All outputs 0: gnt, rvalid, rdata, clk_en, cs, we, addr, wdata.
- States:
  - OFF: clk_en=0, no grants. If any req_i=1 → WAKE.
  - WAKE: clk_en=1 (registered), no grants. Unconditionally → ON.
  - ON: clk_en=1, grants allowed. → OFF when the idle counter reaches IDLE_HOLD.
- Wake latency: req rises in cycle 0 while OFF → clk_en=1 in cycle 1 → gnt in cycle 2.
- Arbitration (ON only):
  - Combinational grant to the first asserted req at or after the rr pointer, searching upward with modulo-N_REQ wrap.
  - At most one gnt bit is set. The ram_* strobes are driven combinationally from the granted requester in the same cycle.
  - On a grant to k, the pointer becomes (k+1) mod N_REQ on the next edge. No grant leaves the pointer unchanged.
- Read return:
  - A granted read pushes the requester id into an RAM_LAT-deep shift pipeline.
  - rvalid_o[id]=1 exactly RAM_LAT cycles after gnt, with rdata_o=ram_rdata_i. Otherwise rdata_o=0.
  - Back-to-back reads are allowed, one per cycle.
- Writes:
  - Complete at gnt with no response.
  - Write followed by read of the same address on the next cycle returns the new data (macro property, no bypass).
- Idle counter (ON only):
  - Resets to 0 on any req or any read in flight; otherwise increments.
  - Saturates at IDLE_HOLD, then transitions to OFF. clk_en falls on that edge.
  - A req in the same cycle the counter would hit IDLE_HOLD wins: state stays ON and the req is granted.
- Clock gating:
  - clk_en never falls while a read is in flight.
  - clk_en changes only on clk_i rising edges, so the gate is glitch-free with the AND2 cell.
- Requester rules:
  - A requester that drops req before gnt is a protocol violation; the arbiter simply skips it.
  - we/addr/wdata are sampled only in the gnt cycle.
- Reset mid-operation: in-flight reads are discarded, no rvalid is emitted, and clk_en drops immediately (asynchronously).

Test Plan:
- Reset, then req_i=01 write addr 0x005 data 0xA5A5A5A5 → clk_en=1 at cycle 1; gnt=01, cs=1, we=1, addr=0x005 at cycle 2.
- Next, req_i=01 read addr 0x005 in ON with RAM_LAT=1 → gnt same cycle; rvalid=01, rdata=0xA5A5A5A5 one cycle later.
- req_i=11 held for 4 cycles from pointer 0 → gnt sequence 01,10,01,10; pointer ends at 0.
- No requests after the last access, IDLE_HOLD=4 → clk_en stays 1 for 4 idle cycles, then falls; state OFF.
- Read granted with RAM_LAT=3, then idle → rvalid 3 cycles after gnt, and clk_en does not fall before idle count restarts after rvalid.
- rst_n_i pulsed low 1 cycle after a read gnt → outputs 0 immediately; no rvalid afterwards; next req needs the WAKE cycle.
